uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of byte-stream requesters (2..8).
REQ-002 SHALL have parameter MAX_BURST, default 64, maximum bytes per grant (1..255).
REQ-003 SHALL have parameter TIMEOUT, default 1000, idle-cycle limit while granted (used only with REQ-027).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester byte valid.
REQ-007 SHALL have port req_data  input  NREQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008 SHALL have port req_ready  output  NREQ  per-requester accept strobe.
REQ-009 SHALL have port tx_req  output  1  byte request to the UART TX engine.
REQ-010 SHALL have port tx_data  output  8  byte to the TX engine.
REQ-011 SHALL have port tx_ready  input  1  TX engine can accept a byte this cycle.
REQ-012 SHALL have port grant_id  output  clog2(NREQ)  index of the current owner.
REQ-013 SHALL have port busy  output  1  high while a grant is held.

Function
REQ-014 SHALL implement the states IDLE and LOCK.
REQ-015 In IDLE with any req_valid bit high, the block SHALL select one requester round-robin, starting after the last owner, register it in grant_id, and enter LOCK on the next edge (1-cycle arbitration latency).
REQ-016 In IDLE, tx_req and all req_ready bits SHALL be 0.
REQ-017 In LOCK, tx_req SHALL equal req_valid[grant_id] and tx_data SHALL equal the grant_id byte, combinationally.
REQ-018 In LOCK, req_ready[grant_id] SHALL equal tx_ready, and all other req_ready bits SHALL be 0.
REQ-019 A transfer SHALL occur on any cycle with tx_req and tx_ready both high; at most one byte transfers per cycle.
REQ-020 An 8-bit burst counter SHALL clear on entry to LOCK and increment on each transfer.
REQ-021 LOCK SHALL return to IDLE on the edge after a transfer of byte 8'h0A (end of packet) or of the MAX_BURST-th byte; when both apply on the same transfer, only one release SHALL occur.
REQ-022 On release, the round-robin pointer SHALL hold the released owner, so the next search starts at owner+1 modulo NREQ.
REQ-023 busy SHALL be 1 exactly while in LOCK.
REQ-024 Requester valid bits that change while another requester is granted SHALL have no effect until the next IDLE cycle.
REQ-025 Deassertion of req_valid[grant_id] in LOCK SHALL NOT release the grant; only REQ-021 and REQ-027 release it.

Reset
REQ-026 While rst_n is sampled low at a clk edge, the block SHALL enter IDLE with grant_id=0, busy=0, burst counter=0 and the pointer at NREQ-1 (first search starts at 0); tx_req and req_ready are therefore 0 from that edge on, including when reset arrives mid-burst, and an in-flight byte on that cycle SHALL NOT count.

Configuration
REQ-027 With macro UART_TX_ARB_TIMEOUT_EN defined, a counter SHALL count consecutive LOCK cycles with req_valid[grant_id] low, clear on every transfer, and force release per REQ-022 when it reaches TIMEOUT.
REQ-028 Without UART_TX_ARB_TIMEOUT_EN, no timeout logic SHALL be synthesized and the TIMEOUT parameter SHALL be ignored.

Structure
REQ-029 Package uart_tx_arb_pkg SHALL hold the state enum (IDLE, LOCK) and the constant EOP_BYTE = 8'h0A.
REQ-030 The round-robin search SHALL be a combinational sub-module rr_pick (inputs: request vector, pointer; outputs: found, index).

Verification
REQ-031 After reset, req_valid=4'b0001 sending "AB\n" with tx_ready=1 -> grant_id=0, three transfers 0x41, 0x42, 0x0A, busy falls the edge after 0x0A.
REQ-032 req_valid=4'b1111 continuously, each requester sending single-byte packets 0x0A -> grant order 0,1,2,3,0, with one IDLE cycle between grants.
REQ-033 MAX_BURST=4, requester 2 streams 10 non-0x0A bytes -> release after the 4th byte; requester 3 is granted next if valid.
REQ-034 tx_ready held at 0 for 20 cycles in LOCK -> no transfer, counter unchanged, req_ready=0, grant held.
REQ-035 rst_n low for one edge after the 2nd byte of a burst -> IDLE, busy=0, grant_id=0, pointer reset; the next grant goes to the lowest valid index.
REQ-036 With UART_TX_ARB_TIMEOUT_EN and TIMEOUT=8, owner drops valid after 1 byte -> release exactly 8 idle cycles later; without the macro -> grant held indefinitely.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART TX byte-stream arbiter.
package uart_tx_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam logic [7:0] EOP_BYTE = 8'h0A;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin search: first set bit of req strictly after ptr,
// wrapping modulo N, so the previous owner is examined last.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = ptr;
    for (int k = 0; k < N; k++) begin
      cand = (cand == IW'(N - 1)) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter locking one byte stream onto a UART TX engine per packet.
// Optional idle-owner timeout release is built with UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 64,
  parameter int TIMEOUT   = 1000,
  localparam int IW       = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_req,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [IW-1:0]     grant_id,
  output logic              busy
);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          locked, owner_vld, xfer, last_beat, to_hit, release_now;
  logic [7:0]    byte_a [NREQ];

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_lane
      assign byte_a[g]    = req_data[8*g +: 8];
      assign req_ready[g] = locked && (gid_q == IW'(g)) && tx_ready;
    end
  endgenerate

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign locked    = (state_q == LOCK);
  assign owner_vld = req_valid[gid_q];
  assign tx_req    = locked && owner_vld;
  assign tx_data   = byte_a[gid_q];
  assign xfer      = tx_req && tx_ready;
  // End of packet and burst limit can coincide; both just feed one release.
  assign last_beat = (tx_data == EOP_BYTE) || (cnt_q == 8'(MAX_BURST - 1));

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_q, to_d;

  // Counts consecutive owner-idle LOCK cycles; the TIMEOUT-th one releases.
  always_comb begin
    to_d   = to_q;
    to_hit = 1'b0;
    if (!locked || owner_vld) begin
      to_d = '0;
    end else if (to_q == TW'(TIMEOUT - 1)) begin
      to_hit = 1'b1;
      to_d   = '0;
    end else begin
      to_d = to_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) to_q <= '0;
    else        to_q <= to_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  assign release_now = (xfer && last_beat) || to_hit;

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = LOCK;
          gid_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      LOCK: begin
        if (xfer) cnt_d = cnt_q + 1'b1;
        if (release_now) begin
          state_d = IDLE;
          ptr_d   = gid_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer resets to the top index so the first search begins at requester 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gid_q   <= '0;
      ptr_q   <= IW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_id = gid_q;
  assign busy     = locked;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed and randomized bench for uart_tx_arb against a packet-level model.
module tb_uart_tx_arb;

  localparam int NREQ = 4;
  localparam int MB   = 4;
  localparam int TO   = 8;

  logic            clk, rst_n, tx_req, tx_ready, busy;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*8-1:0] req_data;
  logic [7:0]      tx_data;
  logic [1:0]      grant_id;

  uart_tx_arb #(.NREQ(NREQ), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_req    (tx_req),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] srcq [NREQ][$];
  logic [7:0] mq   [NREQ][$];
  int         expq [$];
  logic [NREQ-1:0] vmask;
  logic       txr, rstv;
  logic       s_busy, s_txreq, xf;
  logic [1:0] s_gid, xf_id;
  logic [7:0] xf_byte;
  logic [NREQ-1:0] s_rdy;
  int         npass, nfail, ntot;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive sources at negedge, sample outputs, pop accepted bytes.
  task automatic tick();
    @(negedge clk);
    rst_n = rstv;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]      = vmask[i] && (srcq[i].size() > 0);
      req_data[8*i +: 8] = (srcq[i].size() > 0) ? srcq[i][0] : 8'h00;
    end
    tx_ready = txr;
    #1;
    s_busy  = busy;
    s_gid   = grant_id;
    s_txreq = tx_req;
    s_rdy   = req_ready;
    xf      = tx_req && tx_ready;
    xf_id   = grant_id;
    xf_byte = tx_data;
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i] && req_valid[i]) void'(srcq[i].pop_front());
    @(posedge clk);
  endtask

  task automatic clear_q();
    for (int i = 0; i < NREQ; i++) srcq[i].delete();
  endtask

  task automatic do_reset();
    rstv = 1'b0;
    tick();
    rstv = 1'b1;
  endtask

  initial begin
    int mlast, c, n, e, budget;
    logic [7:0] b;
    logic [7:0] s031 [3];
    logic found;
    npass = 0; nfail = 0; ntot = 0;
    rst_n = 1'b0; req_valid = '0; req_data = '0; tx_ready = 1'b0;
    vmask = '0; txr = 1'b0; rstv = 1'b0;
    tick(); tick();
    rstv = 1'b1;
    tick();
    check("reset state", {s_busy, s_gid, s_txreq, s_rdy}, 0);

    // "AB\n" from requester 0
    s031[0] = 8'h41; s031[1] = 8'h42; s031[2] = 8'h0A;
    for (int k = 0; k < 3; k++) srcq[0].push_back(s031[k]);
    vmask = 4'b0001; txr = 1'b1;
    tick();
    check("031 arb quiet", {s_busy, s_txreq, s_rdy}, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("031 byte", {s_busy, s_gid, xf, xf_byte}, {1'b1, 2'd0, 1'b1, s031[k]});
    end
    tick();
    check("031 release", s_busy, 0);

    // all four requesters with single-byte packets
    clear_q(); do_reset();
    srcq[0].push_back(8'h0A); srcq[0].push_back(8'h0A);
    for (int i = 1; i < NREQ; i++) srcq[i].push_back(8'h0A);
    vmask = 4'b1111; txr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("032 gap", s_busy, 0);
      tick();
      check("032 grant", {s_busy, s_gid, xf, xf_byte}, {1'b1, 2'(k % NREQ), 1'b1, 8'h0A});
    end

    // burst limit on requester 2, requester 3 appears mid-grant
    clear_q(); do_reset();
    for (int k = 0; k < 10; k++) srcq[2].push_back(8'h10 + 8'(k));
    vmask = 4'b0100; txr = 1'b1;
    tick();
    check("033 arb", s_busy, 0);
    for (int k = 0; k < MB; k++) begin
      tick();
      check("033 byte", {s_busy, s_gid, xf, xf_byte}, {1'b1, 2'd2, 1'b1, 8'h10 + 8'(k)});
      if (k == 0) begin srcq[3].push_back(8'h0A); vmask = 4'b1100; end
    end
    tick();
    check("033 release", s_busy, 0);
    tick();
    check("033 next owner", {s_busy, s_gid, xf, xf_byte}, {1'b1, 2'd3, 1'b1, 8'h0A});

    // stall with tx_ready low mid-burst
    clear_q(); do_reset();
    for (int k = 0; k < 4; k++) srcq[1].push_back(8'h21 + 8'(k));
    vmask = 4'b0010; txr = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      tick();
      check("034 pre", {xf, xf_byte}, {1'b1, 8'h21 + 8'(k)});
    end
    txr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("034 stall", {s_busy, s_gid, s_rdy, xf}, {1'b1, 2'd1, 4'b0000, 1'b0});
    end
    txr = 1'b1;
    for (int k = 2; k < 4; k++) begin
      tick();
      check("034 post", {s_busy, xf, xf_byte}, {1'b1, 1'b1, 8'h21 + 8'(k)});
    end
    tick();
    check("034 release", s_busy, 0);

    // reset mid-burst; last owner was 1, so a kept pointer would pick 3
    srcq[3].push_back(8'h31); srcq[3].push_back(8'h32);
    srcq[3].push_back(8'h33); srcq[3].push_back(8'h0A);
    vmask = 4'b1000;
    tick();
    for (int k = 0; k < 2; k++) begin
      tick();
      check("035 pre", {s_gid, xf, xf_byte}, {2'd3, 1'b1, 8'h31 + 8'(k)});
    end
    srcq[1].push_back(8'h0A);
    vmask = 4'b1010; txr = 1'b0; rstv = 1'b0;
    tick();
    rstv = 1'b1; txr = 1'b1;
    tick();
    check("035 after reset", {s_busy, s_gid, s_txreq, s_rdy}, 0);
    tick();
    check("035 lowest", {s_busy, s_gid}, {1'b1, 2'd1});

    // owner goes silent after one byte
    clear_q(); do_reset();
    srcq[0].push_back(8'h51); srcq[0].push_back(8'h52); srcq[0].push_back(8'h0A);
    vmask = 4'b0001; txr = 1'b1;
    tick();
    tick();
    check("036 first", {xf, xf_byte}, {1'b1, 8'h51});
    vmask = 4'b0000;
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      tick();
      check("036 held", {s_busy, s_gid}, {1'b1, 2'd0});
    end
    tick();
    check("036 timeout", s_busy, 0);
`else
    for (int k = 0; k < 30; k++) begin
      tick();
      check("036 held", {s_busy, s_gid}, {1'b1, 2'd0});
    end
`endif

    // randomized packets vs packet-level round-robin model
    clear_q(); do_reset();
    vmask = 4'b1111;
    mlast = NREQ - 1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        n = $urandom_range(1, 12);
        for (int k = 0; k < n; k++) begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'h0A) b = 8'h0B;
          if ($urandom_range(0, 3) == 0 || k == n - 1) b = 8'h0A;
          srcq[i].push_back(b);
        end
        mq[i] = srcq[i];
      end
      expq.delete();
      forever begin
        found = 1'b0;
        c = 0;
        for (int k = 1; k <= NREQ; k++) begin
          int cc;
          cc = (mlast + k) % NREQ;
          if (!found && mq[cc].size() > 0) begin found = 1'b1; c = cc; end
        end
        if (!found) break;
        n = 0;
        do begin
          b = mq[c].pop_front();
          expq.push_back(c * 256 + int'(b));
          n++;
        end while (b != 8'h0A && n < MB);
        mlast = c;
      end
      budget = 0;
      while (expq.size() > 0 && budget < 3000) begin
        txr = ($urandom_range(0, 3) != 0);
        tick();
        budget++;
        if (xf) begin
          e = expq.pop_front();
          check("rand xfer", {xf, xf_id, xf_byte}, 32'(1024 + e));
        end
        if (!s_busy) check("rand idle quiet", {s_txreq, s_rdy}, 0);
      end
      check("rand drained", expq.size(), 0);
      tick(); tick();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
